// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller for a 2-way set-associative data cache.
// Fetches the four words of a missing block over a req/ack bus, then writes the line into the victim way.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_req,
    input  logic [ADDR_WIDTH-1:0]              miss_addr,
    input  logic                               lru_way,
    output logic                               mem_req,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic                               mem_ack,
    input  logic [WORD_WIDTH-1:0]              mem_rdata,
    output logic                               fill_we_way_0,
    output logic                               fill_we_way_1,
    output logic [INDEX_BITS-1:0]              fill_index,
    output logic [ADDR_WIDTH-INDEX_BITS-5:0]   fill_tag,
    output logic [4*WORD_WIDTH-1:0]            fill_data,
    output logic                               busy,
    output logic                               refill_done
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]              state;
    logic [1:0]              cnt;
    logic [TAG_BITS-1:0]     tag_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic                    victim;
    logic [4*WORD_WIDTH-1:0] line;

    // Byte and block offset of the miss address never matter: the whole block is fetched from word 0.
    logic unused_offset;
    assign unused_offset = ^miss_addr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            tag_q   <= '0;
            index_q <= '0;
            victim  <= 1'b0;
            line    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        tag_q   <= miss_addr[ADDR_WIDTH-1 -: TAG_BITS];
                        index_q <= miss_addr[INDEX_BITS+3:4];
                        victim  <= lru_way;
                        cnt     <= 2'd0;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        for (int k = 0; k < 4; k++) begin
                            if (cnt == 2'(k)) begin
                                line[k*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
                            end
                        end
                        // cnt wraps back to 0 after the last word
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_addr      = '0;
        fill_we_way_0 = 1'b0;
        fill_we_way_1 = 1'b0;
        refill_done   = 1'b0;
        if (state == FETCH) begin
            mem_req  = 1'b1;
            mem_addr = {tag_q, index_q, cnt, 2'b00};
        end
        if (state == WRITE) begin
            fill_we_way_0 = ~victim;
            fill_we_way_1 = victim;
            refill_done   = 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign fill_index = index_q;
    assign fill_tag   = tag_q;
    assign fill_data  = line;

endmodule
